// File: rtl/mat_mem_arb.sv
// mat_mem_arb
// Arbitrates two burst requesters onto one single-port coefficient memory.
// Port 0 is the Toeplitz engine and port 1 is the host loader.
// The arbiter uses round-robin on a tie and always inserts one idle cycle
// between bursts.
//
// Optional feature: define MAT_ARB_TIMEOUT_EN to build a burst watchdog.
// The watchdog forces a release after TMO cycles of ownership and pulses err.
// Without the macro, err is tied to 0 and bursts can run forever.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req0/1               requester wants memory beats
//   addr0/1              read address, sampled on a beat
//   last0/1              current beat is the final beat of the burst
//   gnt0/1               requester owns the memory port
//   rdata0/1, rvalid0/1  read data and its qualifier, one cycle after a beat
//   mem_addr, mem_rd     single-port memory address and read strobe
//   mem_rdata            memory data, valid one cycle after mem_rd
//   err                  one-cycle pulse on a watchdog-forced release
module mat_mem_arb #(
  parameter int AW  = 8,
  parameter int DW  = 16,
  parameter int TMO = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic          last0,
  input  logic          last1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_rdata,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          last_owner;
  logic          beat0;
  logic          beat1;
  logic          tmo_hit;
  logic          tmo_force;
  logic [DW-1:0] hold0;
  logic [DW-1:0] hold1;

  // Grants come straight from the state register, so they are glitch-free.
  assign gnt0  = (state == OWN0);
  assign gnt1  = (state == OWN1);
  assign beat0 = gnt0 & req0;
  assign beat1 = gnt1 & req1;

  // The memory port is driven only by the owner's beat.
  // It is zeroed otherwise, so a non-owner's inputs can never leak through.
  always_comb begin
    mem_rd   = beat0 | beat1;
    mem_addr = '0;
    if (beat0)
      mem_addr = addr0;
    else if (beat1)
      mem_addr = addr1;
  end

`ifdef MAT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TMO + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);

  logic [CW-1:0] wd_cnt;
  logic          err_q;

  // Idle clears the counter, so it always starts at 0 on entry to OWN n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      wd_cnt <= (state == IDLE) ? '0 : wd_cnt + 1'b1;
      err_q  <= tmo_force;
    end
  end

  assign tmo_hit = (state != IDLE) && (wd_cnt == CNT_LAST);
  assign err     = err_q;
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  // A forced release counts only when the burst would otherwise continue.
  // This means req is still held and the current beat is not the last one.
  assign tmo_force = tmo_hit &&
                     (((state == OWN0) && req0 && !last0) ||
                      ((state == OWN1) && req1 && !last1));

  // Next-state logic. On a tie, the grant goes to the port not served last.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 && req1)
          state_nxt = last_owner ? OWN0 : OWN1;
        else if (req0)
          state_nxt = OWN0;
        else if (req1)
          state_nxt = OWN1;
      end
      OWN0: begin
        if (!req0 || last0 || tmo_force)
          state_nxt = IDLE;
      end
      OWN1: begin
        if (!req1 || last1 || tmo_force)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // last_owner follows every exit from an OWN state, whatever caused it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_owner <= 1'b1;
    end else begin
      state <= state_nxt;
      if ((state == OWN0) && (state_nxt == IDLE))
        last_owner <= 1'b0;
      else if ((state == OWN1) && (state_nxt == IDLE))
        last_owner <= 1'b1;
    end
  end

  // Read return path. rvalid lags the beat by one cycle to line up with
  // the memory latency. Reset clears rvalid, so an in-flight read is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      hold0   <= '0;
      hold1   <= '0;
    end else begin
      rvalid0 <= beat0;
      rvalid1 <= beat1;
      if (rvalid0)
        hold0 <= mem_rdata;
      if (rvalid1)
        hold1 <= mem_rdata;
    end
  end

  // The memory data is passed through in the rvalid cycle.
  // Otherwise the last returned word is presented.
  assign rdata0 = rvalid0 ? mem_rdata : hold0;
  assign rdata1 = rvalid1 ? mem_rdata : hold1;

endmodule

// File: tb/tb_mat_mem_arb.sv
// tb_mat_mem_arb
// Self-checking bench for mat_mem_arb with default parameters (AW=8, DW=16, TMO=64).
// Per-cycle grant and memory-port expectations come from a vector table.
// Read data is tracked by a scoreboard queue that is filled whenever a beat is expected.
// Hand-written sequences cover reset during a burst and the watchdog behaviour.
module tb_mat_mem_arb;

  logic        clk;
  logic        rst_n;
  logic        req0, req1;
  logic [7:0]  addr0, addr1;
  logic        last0, last1;
  logic        gnt0, gnt1;
  logic [15:0] rdata0, rdata1;
  logic        rvalid0, rvalid1;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;
  logic        err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rstn;
    logic       r0;
    logic [7:0] a0;
    logic       l0;
    logic       r1;
    logic [7:0] a1;
    logic       l1;
    logic       g0;
    logic       g1;
    logic       rd;
    logic [7:0] ma;
    logic       v0;
    logic       v1;
  } vec_t;

  typedef struct {
    logic        port;
    logic [15:0] data;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];

  mat_mem_arb #(.AW(8), .DW(16), .TMO(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .last0(last0), .last1(last1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rdata0(rdata0), .rdata1(rdata1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] memf(input logic [7:0] a);
    return {~a, a};
  endfunction

  // Memory model: one-cycle read latency, garbage when not reading.
  always @(posedge clk) begin
    if (mem_rd)
      mem_rdata <= memf(mem_addr);
    else
      mem_rdata <= 16'hDEAD;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every rvalid must match the oldest expected read.
  always @(negedge clk) begin
    if (rvalid0 || rvalid1) begin
      checks++;
      if (rvalid0 && rvalid1) begin
        errors++;
        $display("[TB] FAIL rvalid_both: got both rvalids, expected one at %0t", $time);
      end else if (sbq.size() == 0) begin
        errors++;
        $display("[TB] FAIL rvalid_unexpected: got rvalid0=%0b rvalid1=%0b, expected none at %0t",
                 rvalid0, rvalid1, $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (rvalid1 !== e.port || (rvalid0 ? rdata0 : rdata1) !== e.data) begin
          errors++;
          $display("[TB] FAIL rdata: got port %0d data %0h, expected port %0d data %0h at %0t",
                   rvalid1, rvalid0 ? rdata0 : rdata1, e.port, e.data, $time);
        end
      end
    end
  end

  function automatic vec_t mk(input logic rstn,
                              input logic r0, input logic [7:0] a0, input logic l0,
                              input logic r1, input logic [7:0] a1, input logic l1,
                              input logic g0, input logic g1, input logic rd,
                              input logic [7:0] ma, input logic v0, input logic v1);
    vec_t v;
    v.rstn = rstn; v.r0 = r0; v.a0 = a0; v.l0 = l0;
    v.r1 = r1; v.a1 = a1; v.l1 = l1;
    v.g0 = g0; v.g1 = g1; v.rd = rd; v.ma = ma; v.v0 = v0; v.v1 = v1;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = v.rstn;
    req0 = v.r0; addr0 = v.a0; last0 = v.l0;
    req1 = v.r1; addr1 = v.a1; last1 = v.l1;
    if (v.rd) begin
      e.port = v.g1;
      e.data = memf(v.ma);
      sbq.push_back(e);
    end
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    @(negedge clk);
    chk($sformatf("gnt0[%0d]", idx), 32'(gnt0), 32'(v.g0));
    chk($sformatf("gnt1[%0d]", idx), 32'(gnt1), 32'(v.g1));
    chk($sformatf("mem_rd[%0d]", idx), 32'(mem_rd), 32'(v.rd));
    chk($sformatf("mem_addr[%0d]", idx), 32'(mem_addr), 32'(v.ma));
    chk($sformatf("rvalid0[%0d]", idx), 32'(rvalid0), 32'(v.v0));
    chk($sformatf("rvalid1[%0d]", idx), 32'(rvalid1), 32'(v.v1));
    chk($sformatf("err[%0d]", idx), 32'(err), 32'd0);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0; last0 = 1'b0; last1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0; last0 = 1'b0; last1 = 1'b0;

    // Tie after reset: port 0 wins. Two 4-beat bursts follow, with one idle cycle between them.
    vecs.push_back(mk(0, 0,8'h00,0, 0,8'h00,0, 0,0,0,8'h00, 0,0));
    vecs.push_back(mk(1, 1,8'h10,0, 1,8'h10,0, 0,0,0,8'h00, 0,0));
    vecs.push_back(mk(1, 1,8'h10,0, 1,8'h10,0, 1,0,1,8'h10, 0,0));
    vecs.push_back(mk(1, 1,8'h11,0, 1,8'h3F,1, 1,0,1,8'h11, 1,0));
    vecs.push_back(mk(1, 1,8'h12,0, 1,8'h10,0, 1,0,1,8'h12, 1,0));
    vecs.push_back(mk(1, 1,8'h13,1, 1,8'h10,0, 1,0,1,8'h13, 1,0));
    vecs.push_back(mk(1, 0,8'h00,0, 1,8'h10,0, 0,0,0,8'h00, 1,0));
    vecs.push_back(mk(1, 0,8'h00,0, 1,8'h10,0, 0,1,1,8'h10, 0,0));
    vecs.push_back(mk(1, 0,8'h00,0, 1,8'h11,0, 0,1,1,8'h11, 0,1));
    vecs.push_back(mk(1, 0,8'h00,0, 1,8'h12,0, 0,1,1,8'h12, 0,1));
    vecs.push_back(mk(1, 0,8'h00,0, 1,8'h13,1, 0,1,1,8'h13, 0,1));
    vecs.push_back(mk(1, 0,8'h00,0, 0,8'h00,0, 0,0,0,8'h00, 0,1));
    vecs.push_back(mk(1, 0,8'h00,0, 0,8'h00,0, 0,0,0,8'h00, 0,0));
    // Single-beat burst right after reset release.
    vecs.push_back(mk(0, 0,8'h00,0, 0,8'h00,0, 0,0,0,8'h00, 0,0));
    vecs.push_back(mk(1, 1,8'h05,1, 0,8'h00,0, 0,0,0,8'h00, 0,0));
    vecs.push_back(mk(1, 1,8'h05,1, 0,8'h00,0, 1,0,1,8'h05, 0,0));
    vecs.push_back(mk(1, 0,8'h00,0, 0,8'h00,0, 0,0,0,8'h00, 1,0));
    // Back-to-back single-beat bursts from port 0, separated by an idle cycle.
    vecs.push_back(mk(1, 1,8'h20,1, 0,8'h00,0, 0,0,0,8'h00, 0,0));
    vecs.push_back(mk(1, 1,8'h20,1, 0,8'h00,0, 1,0,1,8'h20, 0,0));
    vecs.push_back(mk(1, 1,8'h21,1, 0,8'h00,0, 0,0,0,8'h00, 1,0));
    vecs.push_back(mk(1, 1,8'h21,1, 0,8'h00,0, 1,0,1,8'h21, 0,0));
    vecs.push_back(mk(1, 0,8'h00,0, 0,8'h00,0, 0,0,0,8'h00, 1,0));
    // req1 drops while port 1 owns the bus: release happens with no beat.
    vecs.push_back(mk(1, 0,8'h00,0, 1,8'h30,0, 0,0,0,8'h00, 0,0));
    vecs.push_back(mk(1, 0,8'h00,0, 1,8'h30,0, 0,1,1,8'h30, 0,0));
    vecs.push_back(mk(1, 0,8'h00,0, 0,8'h31,0, 0,1,0,8'h00, 0,1));
    vecs.push_back(mk(1, 0,8'h00,0, 0,8'h00,0, 0,0,0,8'h00, 0,0));
    // Port 1 runs repeated 2-beat bursts. Port 0 cuts in after the current burst.
    vecs.push_back(mk(1, 0,8'h00,0, 1,8'h40,0, 0,0,0,8'h00, 0,0));
    vecs.push_back(mk(1, 1,8'h50,1, 1,8'h40,0, 0,1,1,8'h40, 0,0));
    vecs.push_back(mk(1, 1,8'h50,1, 1,8'h41,1, 0,1,1,8'h41, 0,1));
    vecs.push_back(mk(1, 1,8'h50,1, 1,8'h42,0, 0,0,0,8'h00, 0,1));
    vecs.push_back(mk(1, 1,8'h50,1, 1,8'h42,0, 1,0,1,8'h50, 0,0));
    vecs.push_back(mk(1, 0,8'h00,0, 1,8'h42,0, 0,0,0,8'h00, 1,0));
    vecs.push_back(mk(1, 0,8'h00,0, 1,8'h42,0, 0,1,1,8'h42, 0,0));
    vecs.push_back(mk(1, 0,8'h00,0, 1,8'h43,1, 0,1,1,8'h43, 0,1));
    vecs.push_back(mk(1, 0,8'h00,0, 0,8'h00,0, 0,0,0,8'h00, 0,1));
    vecs.push_back(mk(1, 0,8'h00,0, 0,8'h00,0, 0,0,0,8'h00, 0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // With no rvalid pending, rdata keeps the last returned words.
    chk("rdata0_hold", 32'(rdata0), 32'(memf(8'h50)));
    chk("rdata1_hold", 32'(rdata1), 32'(memf(8'h43)));

    // Reset asserted during beat 2 of a burst.
    doReset();
    @(posedge clk); #1;
    req0 = 1'b1; addr0 = 8'h60; last0 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_burst_gnt0", 32'(gnt0), 32'd1);
    chk("rst_burst_addr", 32'(mem_addr), 32'h60);
    @(posedge clk); #1;
    addr0 = 8'h61;
    chk("rst_burst_rv0", 32'(rvalid0), 32'd1);
    chk("rst_burst_rd0", 32'(rdata0), 32'(memf(8'h60)));
    rst_n = 1'b0;
    #1;
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("rst_rdata0", 32'(rdata0), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    req0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_gnt0", 32'(gnt0), 32'd0);
      chk("post_rst_rv0", 32'(rvalid0), 32'd0);
    end

    // Long burst from port 1 while port 0 waits.
    doReset();
    @(posedge clk); #1;
    req1 = 1'b1; addr1 = 8'h70; last1 = 1'b0;
`ifdef MAT_ARB_TIMEOUT_EN
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk); #1;
      req0 = 1'b1; addr0 = 8'h71; last0 = 1'b1;
      e.port = 1'b1; e.data = memf(8'h70); sbq.push_back(e);
      @(negedge clk);
      chk("wd_gnt1", 32'(gnt1), 32'd1);
      chk("wd_mem_rd", 32'(mem_rd), 32'd1);
      chk("wd_err_low", 32'(err), 32'd0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("wd_release_gnt1", 32'(gnt1), 32'd0);
    chk("wd_release_gnt0", 32'(gnt0), 32'd0);
    chk("wd_err_pulse", 32'(err), 32'd1);
    @(posedge clk); #1;
    e.port = 1'b0; e.data = memf(8'h71); sbq.push_back(e);
    @(negedge clk);
    chk("wd_next_gnt0", 32'(gnt0), 32'd1);
    chk("wd_next_addr", 32'(mem_addr), 32'h71);
    chk("wd_err_once", 32'(err), 32'd0);
`else
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      req0 = 1'b1; addr0 = 8'h71; last0 = 1'b1;
      e.port = 1'b1; e.data = memf(8'h70); sbq.push_back(e);
      @(negedge clk);
      chk("hold_gnt1", 32'(gnt1), 32'd1);
      chk("hold_gnt0", 32'(gnt0), 32'd0);
      chk("hold_mem_rd", 32'(mem_rd), 32'd1);
      chk("hold_err", 32'(err), 32'd0);
    end
`endif
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
